sha256_block_ctrl: RTL and testbench

// Sequencer for one SHA-256 compression engine built on ch/maj/sum0/sum1/sigm0/sigm1.
// - Accepts a pre-padded 512-bit block as 16 big-endian 32-bit words over a valid/ready stream.
// - Runs the 64 rounds at one round per clock, with in-place message-schedule expansion in a 16-word circular buffer.
// - Folds the result into the chaining hash H and presents the 256-bit digest. Padding and length encoding are upstream.

---
 rtl/sha256_block_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sha256_block_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_ctrl.sv
// rtl/sha256_block_ctrl.sv - SHA-256 single-block sequencer: word load, 64 rounds, chaining fold
module sha256_block_ctrl #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_init,
  input  logic         i_data_valid,
  input  logic [31:0]  i_data,
  output logic         o_data_ready,
  output logic         o_busy,
  output logic         o_digest_valid,
  output logic [255:0] o_digest,
  output logic [5:0]   o_round
);

  typedef enum logic [1:0] {S_LOAD, S_ROUND, S_FINAL} state_t;

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] sum0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] sum1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sigm0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigm1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [5:0]  r;
  logic [31:0] hh [0:7];
  logic        digest_valid;

  logic [31:0] w_buf [0:15];
  logic [31:0] a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r;

  logic        hs;
  logic [3:0]  idx0, idx1, idx9, idx14;
  logic [31:0] wt, t1, t2;

  assign hs = i_data_valid && o_data_ready;

  // Schedule word and round temporaries for the current round index
  always_comb begin
    idx0  = r[3:0];
    idx1  = r[3:0] + 4'd1;
    idx9  = r[3:0] + 4'd9;
    idx14 = r[3:0] + 4'd14;
    if (r < 6'd16) begin
      wt = w_buf[idx0];
    end else begin
      wt = sigm1(w_buf[idx14]) + w_buf[idx9] + sigm0(w_buf[idx1]) + w_buf[idx0];
    end
    t1 = h_r + sum1(e_r) + ch(e_r, f_r, g_r) + K_ROM[r] + wt;
    t2 = sum0(a_r) + maj(a_r, b_r, c_r);
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_LOAD;
    else       state <= state_next;
  end

  // Next-state decode and status outputs
  always_comb begin
    state_next   = state;
    o_data_ready = 1'b0;
    o_busy       = 1'b0;
    o_round      = 6'd0;
    case (state)
      S_LOAD: begin
        o_data_ready = 1'b1;
        if (hs && cnt == 4'd15) state_next = S_ROUND;
      end
      S_ROUND: begin
        o_busy  = 1'b1;
        o_round = r;
        if (r == LAST_ROUND) state_next = S_FINAL;
      end
      S_FINAL: begin
        o_busy     = 1'b1;
        state_next = S_LOAD;
      end
      default: state_next = S_LOAD;
    endcase
  end

  // Word counter, round counter, chaining hash and digest pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt          <= 4'd0;
      r            <= 6'd0;
      digest_valid <= 1'b0;
      for (int i = 0; i < 8; i++) hh[i] <= IV[i];
    end else begin
      digest_valid <= 1'b0;
      case (state)
        S_LOAD: begin
          if (hs) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd0 && i_init) begin
              for (int i = 0; i < 8; i++) hh[i] <= IV[i];
            end
            if (cnt == 4'd15) r <= 6'd0;
          end
        end
        S_ROUND: begin
          if (r == LAST_ROUND) r <= 6'd0;
          else                 r <= r + 6'd1;
        end
        S_FINAL: begin
          hh[0] <= hh[0] + a_r;
          hh[1] <= hh[1] + b_r;
          hh[2] <= hh[2] + c_r;
          hh[3] <= hh[3] + d_r;
          hh[4] <= hh[4] + e_r;
          hh[5] <= hh[5] + f_r;
          hh[6] <= hh[6] + g_r;
          hh[7] <= hh[7] + h_r;
          digest_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Message buffer and working variables; contents are don't-care after reset
  always_ff @(posedge i_clk) begin
    if (state == S_LOAD && hs) begin
      w_buf[cnt] <= i_data;
      if (cnt == 4'd15) begin
        a_r <= hh[0]; b_r <= hh[1]; c_r <= hh[2]; d_r <= hh[3];
        e_r <= hh[4]; f_r <= hh[5]; g_r <= hh[6]; h_r <= hh[7];
      end
    end else if (state == S_ROUND) begin
      if (r >= 6'd16) w_buf[idx0] <= wt;
      h_r <= g_r;
      g_r <= f_r;
      f_r <= e_r;
      e_r <= d_r + t1;
      d_r <= c_r;
      c_r <= b_r;
      b_r <= a_r;
      a_r <= t1 + t2;
    end
  end

  assign o_digest_valid = digest_valid;
  assign o_digest = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb/tb_sha256_block_ctrl.sv - directed bench for sha256_block_ctrl
module tb_sha256_block_ctrl;

  typedef logic [31:0] block_t [16];

  localparam logic [255:0] IV_D    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] MID_D   = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_init = 1'b0;
  logic         i_data_valid = 1'b0;
  logic [31:0]  i_data = 32'd0;
  logic         o_data_ready, o_busy, o_digest_valid;
  logic [255:0] o_digest;
  logic [5:0]   o_round;

  int tests_run = 0;
  int tests_failed = 0;

  block_t blk_abc, blk_empty, blk_two_a, blk_two_b;

  sha256_block_ctrl #(.NUM_ROUNDS(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_init(i_init), .i_data_valid(i_data_valid),
    .i_data(i_data), .o_data_ready(o_data_ready), .o_busy(o_busy),
    .o_digest_valid(o_digest_valid), .o_digest(o_digest), .o_round(o_round)
  );

  always #5 i_clk = ~i_clk;

  task automatic init_blocks();
    blk_abc   = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000018};
    blk_empty = '{32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    blk_two_a = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                  32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                  32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                  32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk_two_b = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000001c0};
  endtask

  // Present 16 words; returns just after the word-15 handshake edge.
  task automatic send_block(input block_t blk, input bit init, input int max_gap, input bit noisy_init);
    for (int i = 0; i < 16; i++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(max_gap, 0);
        i_data_valid = 1'b0;
        repeat (g) begin @(posedge i_clk); #1; end
      end
      i_data_valid = 1'b1;
      i_data = blk[i];
      i_init = (i == 0) ? init : noisy_init;
      for (int k = 0; k < 100 && o_data_ready !== 1'b1; k++) begin @(posedge i_clk); #1; end
      @(posedge i_clk); #1;
    end
    i_data_valid = 1'b0;
    i_init = 1'b0;
  endtask

  // Count edges until the digest pulse; optionally drive junk while busy.
  task automatic wait_digest(input bit noisy, output int n, output int viol);
    n = 0;
    viol = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge i_clk); #1;
      n++;
      if (o_digest_valid === 1'b1) break;
      if (o_data_ready !== 1'b0 || o_busy !== 1'b1) viol++;
      if (noisy) begin
        i_data_valid = 1'b1;
        i_data = $urandom;
        i_init = 1'b1;
      end
    end
    i_data_valid = 1'b0;
    i_init = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    tests_run++;
    if (o_data_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", o_data_ready); end
    tests_run++;
    if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    tests_run++;
    if (o_digest_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", o_digest_valid); end
    tests_run++;
    if (o_digest !== IV_D) begin tests_failed++; $display("FAIL reset_digest got=%h exp=%h", o_digest, IV_D); end
    tests_run++;
    if (o_round !== 6'd0) begin tests_failed++; $display("FAIL reset_round got=%0d exp=0", o_round); end
  endtask

  task automatic test_abc();
    int n, viol;
    send_block(blk_abc, 1'b1, 0, 1'b0);
    wait_digest(1'b0, n, viol);
    tests_run++;
    if (n !== 65) begin tests_failed++; $display("FAIL abc_latency got=%0d edges exp=65", n); end
    tests_run++;
    if (o_digest !== ABC_D) begin tests_failed++; $display("FAIL abc_digest got=%h exp=%h", o_digest, ABC_D); end
    tests_run++;
    if (viol !== 0) begin tests_failed++; $display("FAIL abc_busy_flags got=%0d bad cycles exp=0", viol); end
    tests_run++;
    if (o_data_ready !== 1'b1 || o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL abc_pulse_cycle_load got ready=%b busy=%b exp ready=1 busy=0", o_data_ready, o_busy);
    end
    @(posedge i_clk); #1;
    tests_run++;
    if (o_digest_valid !== 1'b0) begin tests_failed++; $display("FAIL abc_pulse_width got=%b exp=0", o_digest_valid); end
    repeat (3) @(posedge i_clk);
    #1;
    tests_run++;
    if (o_digest !== ABC_D) begin tests_failed++; $display("FAIL abc_digest_hold got=%h exp=%h", o_digest, ABC_D); end
  endtask

  task automatic test_empty();
    int n, viol;
    send_block(blk_empty, 1'b1, 0, 1'b0);
    wait_digest(1'b0, n, viol);
    tests_run++;
    if (o_digest_valid !== 1'b1 || o_digest !== EMPTY_D) begin
      tests_failed++; $display("FAIL empty_digest got=%h valid=%b exp=%h", o_digest, o_digest_valid, EMPTY_D);
    end
  endtask

  task automatic test_two_block();
    int n, viol;
    send_block(blk_two_a, 1'b1, 0, 1'b0);
    wait_digest(1'b0, n, viol);
    tests_run++;
    if (o_digest_valid !== 1'b1 || o_digest !== MID_D) begin
      tests_failed++; $display("FAIL two_block_mid got=%h valid=%b exp=%h", o_digest, o_digest_valid, MID_D);
    end
    send_block(blk_two_b, 1'b0, 0, 1'b0);
    wait_digest(1'b0, n, viol);
    tests_run++;
    if (o_digest_valid !== 1'b1 || o_digest !== TWO_D) begin
      tests_failed++; $display("FAIL two_block_final got=%h valid=%b exp=%h", o_digest, o_digest_valid, TWO_D);
    end
  endtask

  task automatic test_gaps();
    int n, viol;
    send_block(blk_abc, 1'b1, 5, 1'b1);
    wait_digest(1'b1, n, viol);
    tests_run++;
    if (o_digest_valid !== 1'b1 || o_digest !== ABC_D) begin
      tests_failed++; $display("FAIL gaps_digest got=%h valid=%b exp=%h", o_digest, o_digest_valid, ABC_D);
    end
    tests_run++;
    if (viol !== 0) begin tests_failed++; $display("FAIL gaps_ready_low got=%0d bad cycles exp=0", viol); end
    tests_run++;
    if (n !== 65) begin tests_failed++; $display("FAIL gaps_latency got=%0d edges exp=65", n); end
  endtask

  task automatic test_abort();
    int n, viol, pulses;
    send_block(blk_abc, 1'b1, 0, 1'b0);
    for (int k = 0; k < 100 && o_round !== 6'd30; k++) begin @(posedge i_clk); #1; end
    tests_run++;
    if (o_round !== 6'd30) begin tests_failed++; $display("FAIL abort_reach_round got=%0d exp=30", o_round); end
    i_rst = 1'b1;
    #1;
    tests_run++;
    if (o_data_ready !== 1'b1 || o_busy !== 1'b0 || o_digest_valid !== 1'b0 || o_round !== 6'd0 || o_digest !== IV_D) begin
      tests_failed++;
      $display("FAIL abort_reset_outputs got ready=%b busy=%b valid=%b round=%0d digest=%h exp 1 0 0 0 %h",
               o_data_ready, o_busy, o_digest_valid, o_round, o_digest, IV_D);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge i_clk); #1;
      if (o_digest_valid === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL abort_no_pulse got=%0d exp=0", pulses); end
    send_block(blk_abc, 1'b1, 0, 1'b0);
    wait_digest(1'b0, n, viol);
    tests_run++;
    if (o_digest_valid !== 1'b1 || o_digest !== ABC_D) begin
      tests_failed++; $display("FAIL abort_replay got=%h valid=%b exp=%h", o_digest, o_digest_valid, ABC_D);
    end
  endtask

  task automatic test_back_to_back();
    int n, viol;
    send_block(blk_abc, 1'b1, 0, 1'b0);
    wait_digest(1'b0, n, viol);
    tests_run++;
    if (o_digest_valid !== 1'b1 || o_digest !== ABC_D) begin
      tests_failed++; $display("FAIL b2b_first got=%h valid=%b exp=%h", o_digest, o_digest_valid, ABC_D);
    end
    send_block(blk_empty, 1'b1, 0, 1'b0);
    wait_digest(1'b0, n, viol);
    tests_run++;
    if (o_digest_valid !== 1'b1 || o_digest !== EMPTY_D) begin
      tests_failed++; $display("FAIL b2b_second got=%h valid=%b exp=%h", o_digest, o_digest_valid, EMPTY_D);
    end
    tests_run++;
    if (n !== 65) begin tests_failed++; $display("FAIL b2b_latency got=%0d edges exp=65", n); end
  endtask

  initial begin
    init_blocks();
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_gaps();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
